// File: rtl/mult8_seq.sv
// Sequential shift-and-add unsigned multiplier: one partial-product add per clock.
// Optional build macro MULT_ZERO_BYPASS_EN: zero operands complete in one cycle.
module mult8_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [WIDTH-1:0]     mcand_r, mcand_nxt_s;
  logic [WIDTH-1:0]     acc_r, acc_nxt_s;
  logic [WIDTH-1:0]     q_r, q_nxt_s;
  logic [CW-1:0]        cnt_r, cnt_nxt_s;
  logic [2*WIDTH-1:0]   product_r, product_nxt_s;
  logic                 busy_r, done_r;
  logic [WIDTH:0]       addend_s;
  logic [WIDTH:0]       sum_s;
  logic                 zero_op_s;

  // Adder step: carry lands in sum_s[WIDTH] so the top bit is never lost.
  always_comb begin
    addend_s = q_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}};
    sum_s    = {1'b0, acc_r} + addend_s;
  end

  // Next-state and datapath load/shift decode.
  always_comb begin
    state_nxt_s   = state_r;
    mcand_nxt_s   = mcand_r;
    acc_nxt_s     = acc_r;
    q_nxt_s       = q_r;
    cnt_nxt_s     = cnt_r;
    product_nxt_s = product_r;
`ifdef MULT_ZERO_BYPASS_EN
    zero_op_s = (a_in == {WIDTH{1'b0}}) || (b_in == {WIDTH{1'b0}});
`else
    zero_op_s = 1'b0;
`endif
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          mcand_nxt_s = a_in;
          q_nxt_s     = b_in;
          acc_nxt_s   = {WIDTH{1'b0}};
          cnt_nxt_s   = {CW{1'b0}};
          if (zero_op_s) begin
            product_nxt_s = {(2*WIDTH){1'b0}};
            state_nxt_s   = DONE;
          end else begin
            state_nxt_s   = CALC;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        {acc_nxt_s, q_nxt_s} = {sum_s, q_r[WIDTH-1:1]};
        cnt_nxt_s = cnt_r + CNT_ONE;
        if (cnt_r == CNT_LAST) begin
          product_nxt_s = {sum_s, q_r[WIDTH-1:1]};
          state_nxt_s   = DONE;
        end else begin
          state_nxt_s   = CALC;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      mcand_r   <= {WIDTH{1'b0}};
      acc_r     <= {WIDTH{1'b0}};
      q_r       <= {WIDTH{1'b0}};
      cnt_r     <= {CW{1'b0}};
      product_r <= {(2*WIDTH){1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      mcand_r   <= mcand_nxt_s;
      acc_r     <= acc_nxt_s;
      q_r       <= q_nxt_s;
      cnt_r     <= cnt_nxt_s;
      product_r <= product_nxt_s;
      busy_r    <= (state_nxt_s == CALC);
      done_r    <= (state_nxt_s == DONE);
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule

// File: tb/tb_mult8_seq.sv
// Scoreboard bench for mult8_seq: expected products queued at start, popped on done.
module tb_mult8_seq;

  localparam int WIDTH = 8;
`ifdef MULT_ZERO_BYPASS_EN
  localparam int ZERO_LAT  = 1;
  localparam int ZERO_BUSY = 0;
`else
  localparam int ZERO_LAT  = WIDTH + 1;
  localparam int ZERO_BUSY = WIDTH;
`endif

  logic               clk;
  logic               reset;
  logic               start;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  int total_cnt = 0;
  int bad_cnt   = 0;
  logic [2*WIDTH-1:0] exp_q[$];
  logic [2*WIDTH-1:0] last_exp = '0;

  mult8_seq #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      check_val("done_busy_excl", {31'd0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
        check_val("spurious_done", {31'd0, done}, 32'd0);
      end else begin
        check_val("product", {16'd0, product}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  // Waits from the cycle after an accepting edge to done; optionally chains a new start.
  task automatic wait_done(input logic [15:0] prod_exp, input int exp_lat, input int exp_busy,
                           input int inject_at, input bit chain,
                           input logic [7:0] ca, input logic [7:0] cb);
    int n;
    int bc;
    n = 0;
    bc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bc++;
      if (done) begin
        n = i;
        break;
      end
      if (i == inject_at) begin
        check_val("hold_prev", {16'd0, product}, {16'd0, last_exp});
        start = 1'b1;
        a_in  = 8'd99;
        b_in  = 8'd99;
      end
    end
    check_val("latency", n, exp_lat);
    check_val("busy_cycles", bc, exp_busy);
    last_exp = prod_exp;
    if (chain) begin
      start = 1'b1;
      a_in  = ca;
      b_in  = cb;
      exp_q.push_back({8'd0, ca} * {8'd0, cb});
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int exp_lat,
                        input int exp_busy, input int inject_at);
    logic [15:0] p;
    p = {8'd0, a} * {8'd0, b};
    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    exp_q.push_back(p);
    wait_done(p, exp_lat, exp_busy, inject_at, 1'b0, 8'd0, 8'd0);
  endtask

  initial begin
    logic any_done;
    reset = 1'b1;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    #12;
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_product", {16'd0, product}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(8'd13, 8'd11, WIDTH + 1, WIDTH, 0);
    repeat (3) @(negedge clk);
    check_val("hold_after", {16'd0, product}, 32'd143);

    run_op(8'd255, 8'd255, WIDTH + 1, WIDTH, 0);
    run_op(8'd0, 8'd200, ZERO_LAT, ZERO_BUSY, 0);
    run_op(8'd77, 8'd0, ZERO_LAT, ZERO_BUSY, 0);

    // start mid-CALC must be ignored; product holds the previous result meanwhile
    run_op(8'd7, 8'd6, WIDTH + 1, WIDTH, 4);
    repeat (2) @(negedge clk);

    // back-to-back: second start accepted in the DONE cycle
    @(negedge clk);
    start = 1'b1;
    a_in  = 8'd3;
    b_in  = 8'd5;
    exp_q.push_back(16'd15);
    wait_done(16'd15, WIDTH + 1, WIDTH, 0, 1'b1, 8'd10, 8'd20);
    wait_done(16'd200, WIDTH + 1, WIDTH, 0, 1'b0, 8'd0, 8'd0);

    for (int k = 0; k < 5; k++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      ra = 8'($urandom_range(1, 255));
      rb = 8'($urandom_range(1, 255));
      run_op(ra, rb, WIDTH + 1, WIDTH, 0);
    end

    // asynchronous reset in the middle of CALC aborts the operation
    @(negedge clk);
    start = 1'b1;
    a_in  = 8'd100;
    b_in  = 8'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_val("arst_busy", {31'd0, busy}, 32'd0);
    check_val("arst_done", {31'd0, done}, 32'd0);
    check_val("arst_product", {16'd0, product}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    any_done = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done) any_done = 1'b1;
    end
    check_val("no_done_after_rst", {31'd0, any_done}, 32'd0);
    check_val("product_after_rst", {16'd0, product}, 32'd0);
    check_val("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
